// File: rtl/io_bus_pkg.sv
// io_bus_pkg
//   Shared definitions for the peripheral I/O bus arbiter and any block that
//   decodes the same address windows (for example the chip-select decoder).
//   Contents: arbiter FSM state encoding, peripheral page constants
//   (addr[15:8]) and the bus data/address width.
package io_bus_pkg;

  localparam int BUS_W = 16;

  // Peripheral pages, compared against addr[15:8]
  localparam logic [7:0] WIN_MULT   = 8'h67;
  localparam logic [7:0] WIN_DIV    = 8'h68;
  localparam logic [7:0] WIN_UART   = 8'h69;
  localparam logic [7:0] WIN_DP_RAM = 8'h70;
  localparam logic [7:0] WIN_CONFIG = 8'h71;

  localparam logic [7:0] WAIT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/io_bus_win_check.sv
// io_bus_win_check
//   Combinational check that an address page lies inside [LO, HI] inclusive.
//   Kept separate so the chip-select decoder can reuse the same compare.
//   Ports:
//     page    in  8  addr[15:8] of the access being checked
//     in_win  out 1  high when LO <= page <= HI
module io_bus_win_check
  import io_bus_pkg::*;
#(
  parameter logic [7:0] LO = WIN_MULT,
  parameter logic [7:0] HI = WIN_CONFIG
) (
  input  logic [7:0] page,
  output logic       in_win
);

  assign in_win = (page >= LO) && (page <= HI);

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the peripheral I/O bus between the J1 CPU and an auxiliary master
//   (camera DMA / frame mover). The CPU always has priority and passes straight
//   through with zero latency; an aux transaction is latched on aux_req in IDLE
//   and issued on the first cycle in which the CPU is not strobing rd/wr.
//
//   Optional build macro: AUX_TIMEOUT_EN
//     defined   - an aux transaction still pending after TIMEOUT deferred
//                 cycles is aborted with aux_err, nothing is issued
//     undefined - a pending aux transaction waits indefinitely
//
//   Ports:
//     sys_clk_i    in   1   system clock, rising edge
//     sys_rst_i    in   1   asynchronous reset, active-low
//     cpu_rd/wr    in   1   J1 io strobes
//     cpu_addr     in   16  J1 io address
//     cpu_dout     in   16  J1 write data
//     cpu_din      out  16  read data to J1 (always bus_din)
//     aux_req      in   1   request strobe, sampled in IDLE only
//     aux_we       in   1   1 = write, 0 = read
//     aux_addr     in   16  aux address
//     aux_wdata    in   16  aux write data
//     aux_busy     out  1   transaction in flight (after acceptance up to DONE)
//     aux_ack      out  1   one-cycle completion pulse
//     aux_err      out  1   with aux_ack: rejected (bad window) or aborted
//     aux_rdata    out  16  last aux read data, held until the next good read
//     aux_wait     out  8   saturating deferred-cycle count of last transaction
//     bus_rd/wr    out  1   strobes to decoder and peripherals
//     bus_addr     out  16  address to decoder and peripherals
//     bus_dout     out  16  write data to peripherals
//     bus_din      in   16  read mux output
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter logic [7:0] WIN_LO  = WIN_MULT,
   parameter logic [7:0] WIN_HI  = WIN_CONFIG,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic             sys_clk_i,
   input  logic             sys_rst_i,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [BUS_W-1:0] cpu_addr,
   input  logic [BUS_W-1:0] cpu_dout,
   output logic [BUS_W-1:0] cpu_din,
   input  logic             aux_req,
   input  logic             aux_we,
   input  logic [BUS_W-1:0] aux_addr,
   input  logic [BUS_W-1:0] aux_wdata,
   output logic             aux_busy,
   output logic             aux_ack,
   output logic             aux_err,
   output logic [BUS_W-1:0] aux_rdata,
   output logic [7:0]       aux_wait,
   output logic             bus_rd,
   output logic             bus_wr,
   output logic [BUS_W-1:0] bus_addr,
   output logic [BUS_W-1:0] bus_dout,
   input  logic [BUS_W-1:0] bus_din
);

   arb_state_t       state;
   logic             aux_we_q;
   logic [BUS_W-1:0] aux_addr_q;
   logic [BUS_W-1:0] aux_wdata_q;
   logic [7:0]       wait_cnt;

   logic cpu_active;
   logic req_in_win;
   logic timeout_hit;
   logic aux_issue;

   io_bus_win_check #(
      .LO (WIN_LO),
      .HI (WIN_HI)
   ) u_win_check (
      .page   (aux_addr[15:8]),
      .in_win (req_in_win)
   );

   assign cpu_active = cpu_rd | cpu_wr;

`ifdef AUX_TIMEOUT_EN
   assign timeout_hit = (wait_cnt == TIMEOUT);
`else
   assign timeout_hit = 1'b0;
`endif

   // The aux master owns the bus only in a PEND cycle the CPU leaves free;
   // an expired timeout abandons the transaction instead of issuing it.
   assign aux_issue = (state == ST_PEND) && !cpu_active && !timeout_hit;

   assign cpu_din = bus_din;

   // CPU signals pass through even without a strobe, since the J1 read mux
   // selects on the address alone.
   always_comb begin
      bus_rd   = cpu_rd;
      bus_wr   = cpu_wr;
      bus_addr = cpu_addr;
      bus_dout = cpu_dout;
      if (aux_issue) begin
         bus_rd   = !aux_we_q;
         bus_wr   = aux_we_q;
         bus_addr = aux_addr_q;
         bus_dout = aux_wdata_q;
      end
   end

   // Arbiter FSM. Status outputs are registered on the edge that enters DONE,
   // so aux_ack/aux_err are high exactly for the DONE cycle. Read data is
   // captured on the closing edge of the issue cycle because peripheral read
   // data reaches the mux combinationally.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state       <= ST_IDLE;
         aux_we_q    <= 1'b0;
         aux_addr_q  <= '0;
         aux_wdata_q <= '0;
         wait_cnt    <= 8'd0;
         aux_busy    <= 1'b0;
         aux_ack     <= 1'b0;
         aux_err     <= 1'b0;
         aux_rdata   <= '0;
         aux_wait    <= 8'd0;
      end else begin
         aux_ack <= 1'b0;
         aux_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (aux_req) begin
                  aux_we_q    <= aux_we;
                  aux_addr_q  <= aux_addr;
                  aux_wdata_q <= aux_wdata;
                  wait_cnt    <= 8'd0;
                  aux_busy    <= 1'b1;
                  if (req_in_win) begin
                     state <= ST_PEND;
                  end else begin
                     state    <= ST_DONE;
                     aux_ack  <= 1'b1;
                     aux_err  <= 1'b1;
                     aux_wait <= 8'd0;
                  end
               end
            end
            ST_PEND: begin
               if (timeout_hit) begin
                  state    <= ST_DONE;
                  aux_ack  <= 1'b1;
                  aux_err  <= 1'b1;
                  aux_wait <= wait_cnt;
               end else if (cpu_active) begin
                  if (wait_cnt != WAIT_MAX) begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end else begin
                  if (!aux_we_q) begin
                     aux_rdata <= bus_din;
                  end
                  state    <= ST_DONE;
                  aux_ack  <= 1'b1;
                  aux_wait <= wait_cnt;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               aux_busy <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               aux_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Directed bench for io_bus_arbiter: reset values, aux read/write, CPU
//   deferral, window boundaries, request-in-DONE, long deferral (timeout
//   abort when AUX_TIMEOUT_EN is defined, TIMEOUT=4) and reset mid-PEND.
module tb_io_bus_arbiter;

   logic        sys_clk_i;
   logic        sys_rst_i;
   logic        cpu_rd, cpu_wr;
   logic [15:0] cpu_addr, cpu_dout, cpu_din;
   logic        aux_req, aux_we;
   logic [15:0] aux_addr, aux_wdata;
   logic        aux_busy, aux_ack, aux_err;
   logic [15:0] aux_rdata;
   logic [7:0]  aux_wait;
   logic        bus_rd, bus_wr;
   logic [15:0] bus_addr, bus_dout, bus_din;

   int vectors_applied = 0;
   int miscompares     = 0;

   io_bus_arbiter #(.TIMEOUT(8'd4)) dut (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .aux_req   (aux_req),
      .aux_we    (aux_we),
      .aux_addr  (aux_addr),
      .aux_wdata (aux_wdata),
      .aux_busy  (aux_busy),
      .aux_ack   (aux_ack),
      .aux_err   (aux_err),
      .aux_rdata (aux_rdata),
      .aux_wait  (aux_wait),
      .bus_rd    (bus_rd),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_dout  (bus_dout),
      .bus_din   (bus_din)
   );

   // Free-running system clock, 10 time-unit period
   initial sys_clk_i = 1'b0;
   always #5 sys_clk_i = ~sys_clk_i;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic nextCycle();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic c_rd, input logic c_wr,
                                input logic [15:0] c_addr, input logic [15:0] c_dout,
                                input logic a_req, input logic a_we,
                                input logic [15:0] a_addr, input logic [15:0] a_wdata,
                                input logic [15:0] b_din);
      cpu_rd    = c_rd;
      cpu_wr    = c_wr;
      cpu_addr  = c_addr;
      cpu_dout  = c_dout;
      aux_req   = a_req;
      aux_we    = a_we;
      aux_addr  = a_addr;
      aux_wdata = a_wdata;
      bus_din   = b_din;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors_applied++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed test sequence
   initial begin
      sys_rst_i = 1'b0;
      applyStimulus(0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      nextCycle();
      nextCycle();
      // Reset state
      checkOutput("rst_busy", aux_busy, 0);
      checkOutput("rst_ack", aux_ack, 0);
      checkOutput("rst_err", aux_err, 0);
      checkOutput("rst_rdata", aux_rdata, 16'h0000);
      checkOutput("rst_wait", aux_wait, 0);
      checkOutput("rst_bus_addr", bus_addr, 16'h0100);
      @(negedge sys_clk_i);
      sys_rst_i = 1'b1;

      // Aux read 0x6702, no CPU traffic
      nextCycle();
      applyStimulus(0, 0, 16'h0100, 16'h0000, 1, 0, 16'h6702, 16'h0000, 16'h1234);
      checkOutput("rd_n_bus_rd", bus_rd, 0);
      checkOutput("rd_n_bus_addr", bus_addr, 16'h0100);
      nextCycle();
      applyStimulus(0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1234);
      checkOutput("rd_n1_bus_rd", bus_rd, 1);
      checkOutput("rd_n1_bus_wr", bus_wr, 0);
      checkOutput("rd_n1_bus_addr", bus_addr, 16'h6702);
      checkOutput("rd_n1_busy", aux_busy, 1);
      checkOutput("rd_n1_ack", aux_ack, 0);
      nextCycle();
      applyStimulus(0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      checkOutput("rd_n2_ack", aux_ack, 1);
      checkOutput("rd_n2_err", aux_err, 0);
      checkOutput("rd_n2_rdata", aux_rdata, 16'h1234);
      checkOutput("rd_n2_wait", aux_wait, 0);
      checkOutput("rd_n2_bus_rd", bus_rd, 0);
      nextCycle();
      checkOutput("rd_n3_ack", aux_ack, 0);
      checkOutput("rd_n3_busy", aux_busy, 0);
      checkOutput("rd_n3_rdata", aux_rdata, 16'h1234);

      // Aux write 0xBEEF to 0x7010 with cpu_wr held for 3 cycles
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h7010, 16'hBEEF, 16'h0000);
      checkOutput("wr_n_bus_wr", bus_wr, 0);
      for (int i = 1; i <= 3; i++) begin
         nextCycle();
         applyStimulus(0, 1, 16'h6900 + 16'(i), 16'h0050 + 16'(i), 0, 0, 16'h0000, 16'h0000, 16'h0000);
         checkOutput("wr_defer_bus_wr", bus_wr, 1);
         checkOutput("wr_defer_bus_rd", bus_rd, 0);
         checkOutput("wr_defer_bus_addr", bus_addr, 16'h6900 + 16'(i));
         checkOutput("wr_defer_bus_dout", bus_dout, 16'h0050 + 16'(i));
         checkOutput("wr_defer_ack", aux_ack, 0);
      end
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      checkOutput("wr_issue_bus_wr", bus_wr, 1);
      checkOutput("wr_issue_bus_rd", bus_rd, 0);
      checkOutput("wr_issue_bus_addr", bus_addr, 16'h7010);
      checkOutput("wr_issue_bus_dout", bus_dout, 16'hBEEF);
      nextCycle();
      checkOutput("wr_ack", aux_ack, 1);
      checkOutput("wr_err", aux_err, 0);
      checkOutput("wr_wait", aux_wait, 3);
      checkOutput("wr_rdata_kept", aux_rdata, 16'h1234);
      checkOutput("wr_bus_wr_after", bus_wr, 0);

      // CPU read in the same cycles as the aux request
      nextCycle();
      applyStimulus(1, 0, 16'h6800, 16'h0000, 1, 0, 16'h6900, 16'h0000, 16'hA5A5);
      checkOutput("cr_n_cpu_din", cpu_din, 16'hA5A5);
      checkOutput("cr_n_bus_addr", bus_addr, 16'h6800);
      checkOutput("cr_n_bus_rd", bus_rd, 1);
      nextCycle();
      applyStimulus(1, 0, 16'h6801, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1111);
      checkOutput("cr_n1_cpu_din", cpu_din, 16'h1111);
      checkOutput("cr_n1_bus_addr", bus_addr, 16'h6801);
      checkOutput("cr_n1_bus_wr", bus_wr, 0);
      checkOutput("cr_n1_busy", aux_busy, 1);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h2222);
      checkOutput("cr_issue_bus_addr", bus_addr, 16'h6900);
      checkOutput("cr_issue_bus_rd", bus_rd, 1);
      checkOutput("cr_issue_cpu_din", cpu_din, 16'h2222);
      nextCycle();
      checkOutput("cr_ack", aux_ack, 1);
      checkOutput("cr_rdata", aux_rdata, 16'h2222);
      checkOutput("cr_wait", aux_wait, 1);

      // Out-of-window request 0x5000; a request held during DONE is ignored
      nextCycle();
      applyStimulus(0, 0, 16'h0200, 16'h0000, 1, 0, 16'h5000, 16'h0000, 16'h9999);
      checkOutput("ow_n_bus_rd", bus_rd, 0);
      checkOutput("ow_n_bus_wr", bus_wr, 0);
      nextCycle();
      applyStimulus(0, 0, 16'h0200, 16'h0000, 1, 0, 16'h6700, 16'h0000, 16'h9999);
      checkOutput("ow_ack", aux_ack, 1);
      checkOutput("ow_err", aux_err, 1);
      checkOutput("ow_wait", aux_wait, 0);
      checkOutput("ow_rdata_kept", aux_rdata, 16'h2222);
      checkOutput("ow_bus_rd", bus_rd, 0);
      checkOutput("ow_bus_addr", bus_addr, 16'h0200);
      nextCycle();
      applyStimulus(0, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h9999);
      checkOutput("done_req_ignored_busy", aux_busy, 0);
      checkOutput("done_req_ignored_bus_rd", bus_rd, 0);
      checkOutput("done_req_ignored_ack", aux_ack, 0);

      // Upper window edge 0x71FF is legal
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h71FF, 16'h0000, 16'h0F0F);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0F0F);
      checkOutput("hi_bus_rd", bus_rd, 1);
      checkOutput("hi_bus_addr", bus_addr, 16'h71FF);
      nextCycle();
      checkOutput("hi_ack", aux_ack, 1);
      checkOutput("hi_err", aux_err, 0);
      checkOutput("hi_rdata", aux_rdata, 16'h0F0F);

      // Just below the lower edge 0x66FF is rejected
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h66FF, 16'h0000, 16'h4444);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h4444);
      checkOutput("lo_ack", aux_ack, 1);
      checkOutput("lo_err", aux_err, 1);
      checkOutput("lo_bus_rd", bus_rd, 0);
      checkOutput("lo_rdata_kept", aux_rdata, 16'h0F0F);
      nextCycle();

      // Long CPU write burst against an aux write to 0x6900
      applyStimulus(0, 1, 16'h6800, 16'h0001, 1, 1, 16'h6900, 16'hCAFE, 16'h0000);
      for (int i = 1; i <= 6; i++) begin
         nextCycle();
         applyStimulus(0, 1, 16'h6800 + 16'(i), 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000);
         checkOutput("long_bus_addr", bus_addr, 16'h6800 + 16'(i));
         checkOutput("long_bus_dout", bus_dout, 16'h0001);
`ifdef AUX_TIMEOUT_EN
         checkOutput("long_ack", aux_ack, (i == 6) ? 16'd1 : 16'd0);
`else
         checkOutput("long_ack", aux_ack, 0);
`endif
      end
`ifdef AUX_TIMEOUT_EN
      checkOutput("to_err", aux_err, 1);
      checkOutput("to_wait", aux_wait, 4);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      checkOutput("to_no_strobe", bus_wr, 0);
      checkOutput("to_busy", aux_busy, 0);
`else
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      checkOutput("long_issue_bus_wr", bus_wr, 1);
      checkOutput("long_issue_bus_addr", bus_addr, 16'h6900);
      checkOutput("long_issue_bus_dout", bus_dout, 16'hCAFE);
      nextCycle();
      checkOutput("long_ack_final", aux_ack, 1);
      checkOutput("long_err", aux_err, 0);
      checkOutput("long_wait", aux_wait, 6);
`endif

      // Reset while PEND
      nextCycle();
      applyStimulus(1, 0, 16'h6800, 16'h0000, 1, 0, 16'h6900, 16'h0000, 16'h5555);
      nextCycle();
      applyStimulus(1, 0, 16'h6800, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5555);
      checkOutput("rp_busy_before", aux_busy, 1);
      sys_rst_i = 1'b0;
      #1;
      checkOutput("rp_busy", aux_busy, 0);
      checkOutput("rp_ack", aux_ack, 0);
      checkOutput("rp_rdata", aux_rdata, 16'h0000);
      checkOutput("rp_wait", aux_wait, 0);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5555);
      checkOutput("rp_bus_rd", bus_rd, 0);
      checkOutput("rp_ack_in_reset", aux_ack, 0);
      @(negedge sys_clk_i);
      sys_rst_i = 1'b1;
      nextCycle();
      checkOutput("rp_ack_after", aux_ack, 0);
      checkOutput("rp_busy_after", aux_busy, 0);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h6A00, 16'h0000, 16'h7777);
      nextCycle();
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h7777);
      checkOutput("rp_retry_bus_rd", bus_rd, 1);
      checkOutput("rp_retry_bus_addr", bus_addr, 16'h6A00);
      nextCycle();
      checkOutput("rp_retry_ack", aux_ack, 1);
      checkOutput("rp_retry_err", aux_err, 0);
      checkOutput("rp_retry_rdata", aux_rdata, 16'h7777);
      checkOutput("rp_retry_wait", aux_wait, 0);

      nextCycle();
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the SoC peripheral I/O bus (mult, div, uart, dp_ram, config windows) between two masters: the J1 CPU and an auxiliary master (camera DMA / frame mover).
- CPU has absolute priority and is never stalled; its signals pass through with zero latency.
- Auxiliary transactions use a req/ack handshake and are issued only in cycles where the CPU is not strobing rd/wr.
- Sits between cpu0 and the chip-select decoder / read mux.

Parameters:
- WIN_LO, 8'h67, lowest legal addr[15:8] for aux accesses
- WIN_HI, 8'h71, highest legal addr[15:8] for aux accesses
- TIMEOUT, 255, max PEND cycles before abort (only with AUX_TIMEOUT_EN)

Ports:
- sys_clk_i  in  1  system clock, rising edge
- sys_rst_i  in  1  asynchronous reset, active-low
- cpu_rd  in  1  J1 io_rd
- cpu_wr  in  1  J1 io_wr
- cpu_addr  in  16  J1 io_addr
- cpu_dout  in  16  J1 write data
- cpu_din  out  16  read data to J1; always equals bus_din
- aux_req  in  1  request strobe, sampled in IDLE only
- aux_we  in  1  1 = write, 0 = read
- aux_addr  in  16  aux address
- aux_wdata  in  16  aux write data
- aux_busy  out  1  high from the cycle after acceptance through the DONE cycle
- aux_ack  out  1  one-cycle completion pulse
- aux_err  out  1  high with aux_ack if the transaction was rejected or aborted
- aux_rdata  out  16  read data, valid while aux_ack=1, held until next read completes
- aux_wait  out  8  saturating count of deferred cycles in the last transaction
- bus_rd  out  1  to decoder and peripherals
- bus_wr  out  1  to decoder and peripherals
- bus_addr  out  16  to decoder and peripherals
- bus_dout  out  16  write data to peripherals
- bus_din  in  16  read mux output

Behaviour:
- Reset (sys_rst_i=0, async):
  - state=IDLE
  - aux_busy=0, aux_ack=0, aux_err=0, aux_rdata=0, aux_wait=0
  - latched request registers cleared
- Bus drive is combinational:
  - default: bus_* = cpu_*, including cycles with no strobe, because the J1 read mux depends on the address.
  - aux issue cycle only: bus_addr=aux_addr_q, bus_dout=aux_wdata_q, bus_rd=!aux_we_q, bus_wr=aux_we_q.
- FSM states: IDLE, PEND, DONE.
  - IDLE:
    - aux_req=1 latches aux_we, aux_addr and aux_wdata into the _q registers and clears wait_cnt.
    - If aux_addr[15:8] is outside [WIN_LO, WIN_HI], go to DONE with err=1 and issue nothing.
    - Otherwise go to PEND.
  - PEND:
    - If cpu_rd|cpu_wr=1, defer: wait_cnt+1, saturating at 255.
    - Else this is the issue cycle. For a read, aux_rdata<=bus_din on the closing edge. Go to DONE, err=0.
  - DONE:
    - aux_ack=1, aux_err=err, aux_wait=wait_cnt.
    - Go to IDLE.
    - aux_req during DONE is ignored; the requester must re-assert it in IDLE.
- Minimum latency with no CPU activity: req at cycle N, issue at N+1, ack at N+2.
- Each deferred cycle adds 1 to the latency.
- An aux read samples bus_din in the same cycle as the bus_rd strobe (peripheral read data is combinational to the mux).
- CPU rd/wr in the same cycle as a PEND issue opportunity: CPU wins and the aux transaction defers. There is never a bus collision.
- Reset mid-transaction: aborts with no ack; the requester must retry.
- aux_rdata is unchanged by writes and by errored transactions.

Optional Feature:
- AUX_TIMEOUT_EN defined:
  - In PEND, if wait_cnt reaches TIMEOUT, go to DONE with err=1.
  - No bus access is issued.
- AUX_TIMEOUT_EN undefined:
  - PEND waits indefinitely.
  - wait_cnt still saturates at 255.

Decomposition:
- Package io_bus_pkg holds:
  - FSM state encodings (2-bit)
  - window constants (8'h67 mult, 8'h68 div, 8'h69 uart, 8'h70 dp_ram, 8'h71 config)
  - bus width constant 16
- No sub-module required.
- Optional sub-module io_bus_win_check (address window compare) so the decoder can reuse it.

Test Plan:
- Aux read at addr 16'h6702, no CPU activity, bus_din=16'h1234:
  - bus_rd=1 with bus_addr=16'h6702 at N+1
  - aux_ack=1, aux_rdata=16'h1234, aux_wait=0, aux_err=0 at N+2
- Aux write 16'hBEEF to 16'h7010 while cpu_wr is held for 3 cycles:
  - bus shows CPU traffic for those 3 cycles
  - aux write issues on the first free cycle
  - ack with aux_wait=3
- CPU rd and aux request in the same cycles:
  - cpu_din=bus_din, matching the CPU address, every cycle
  - no aux strobe while cpu_rd=1
- Aux request to 16'h5000 (outside window):
  - no bus_rd/bus_wr from aux
  - aux_ack=1 and aux_err=1 at N+1
  - aux_rdata unchanged
- AUX_TIMEOUT_EN with TIMEOUT=4 and CPU strobing continuously:
  - ack with err=1 and aux_wait=4
  - no aux strobe ever
- sys_rst_i=0 asserted while in PEND:
  - outputs go to reset values immediately
  - aux_ack is never pulsed
  - after release, a new request completes normally
